// File: rtl/rto_frame_decoder_if.sv
`timescale 1ns/1ps
// Line-side input and word-side outputs of the RTO frame decoder.
interface rto_frame_decoder_if #(
    parameter int DATA_W = 8
);
    logic              rto_in;
    logic [DATA_W-1:0] data_out;
    logic              data_valid;
    logic              code_err;
    logic              busy;

    modport master (output rto_in, input data_out, data_valid, code_err, busy);
    modport slave  (input rto_in, output data_out, data_valid, code_err, busy);
endinterface

// File: rtl/rto_frame_decoder.sv
`timescale 1ns/1ps
// Oversampling RTO line receiver: start, DATA_W bits LSB first, stop; flags code violations.
// data_valid lands (DATA_W+1)*OVS+OVS/4+3 cycles after the first low sample; no backpressure, one-cycle strobes.
module rto_frame_decoder #(
    parameter int OVS    = 16,
    parameter int DATA_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    rto_frame_decoder_if.slave rx
);
    localparam int CW = (OVS > 1) ? $clog2(OVS) : 1;
    localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(OVS - 1);
    localparam logic [CW-1:0] CNT_SAMP = CW'(OVS / 4);
    localparam logic [CW-1:0] CNT_RET  = CW'(3 * OVS / 4);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    state_t            state_q, state_d;
    logic              sync1_q, sync2_q, prev_q;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [BW-1:0]     bit_q, bit_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;
    logic              err_q, err_d;
    logic              busy;

    logic fall, at_samp, at_ret, at_wrap;

    assign fall    = prev_q & ~sync2_q;
    assign at_samp = (cnt_q == CNT_SAMP);
    assign at_ret  = (cnt_q == CNT_RET);
    assign at_wrap = (cnt_q == CNT_LAST);

    // Synchroniser resets to the idle level so reset release never looks like a start edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
        end else begin
            sync1_q <= rx.rto_in;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (fall) state_d = S_START;
            end
            S_START: begin
                if (at_samp && sync2_q)     state_d = S_IDLE;
                else if (at_ret && !sync2_q) state_d = S_IDLE;
                else if (at_wrap)            state_d = S_DATA;
            end
            S_DATA: begin
                if (at_ret && !sync2_q)                 state_d = S_IDLE;
                else if (at_wrap && (bit_q == BIT_LAST)) state_d = S_STOP;
            end
            S_STOP: begin
                // Linger one cycle after the good stop sample so busy covers the valid strobe.
                if (valid_q)                  state_d = S_IDLE;
                else if (at_samp && !sync2_q) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cnt_d   = at_wrap ? '0 : cnt_q + CW'(1);
        bit_d   = bit_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
        busy    = (state_q != S_IDLE);
        case (state_q)
            S_IDLE: begin
                cnt_d = fall ? CW'(1) : '0;
                bit_d = '0;
            end
            S_START: begin
                bit_d = '0;
                if (at_ret && !sync2_q) err_d = 1'b1;
            end
            S_DATA: begin
                if (at_samp) shift_d = (shift_q >> 1) | (DATA_W'(sync2_q) << (DATA_W - 1));
                if (at_ret && !sync2_q) err_d = 1'b1;
                if (at_wrap) bit_d = bit_q + BW'(1);
            end
            S_STOP: begin
                if (at_samp && !valid_q) begin
                    if (sync2_q) begin
                        valid_d = 1'b1;
                        data_d  = shift_q;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    assign rx.data_out   = data_q;
    assign rx.data_valid = valid_q;
    assign rx.code_err   = err_q;
    assign rx.busy       = busy;
endmodule

// File: tb/tb_rto_frame_decoder.sv
`timescale 1ns/1ps
// Directed bench for rto_frame_decoder: cycle index N means "the value sampled by clock edge N".
module tb_rto_frame_decoder;
    localparam int OVS    = 16;
    localparam int DATA_W = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rto_frame_decoder_if #(.DATA_W(DATA_W)) bus ();
    rto_frame_decoder #(.OVS(OVS), .DATA_W(DATA_W)) dut (
        .clk (clk),
        .rst (rst),
        .rx  (bus)
    );

    int errors = 0;
    int checks = 0;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int   dv_cyc[$];
    int   dv_dat[$];
    int   ce_cyc[$];
    int   rise_q[$];
    int   fall_q[$];
    int   busy_hi_cnt = 0;
    int   dv_wide = 0;
    int   ce_wide = 0;
    int   both_cnt = 0;
    logic busy_prev = 1'b0;
    logic dv_prev = 1'b0;
    logic ce_prev = 1'b0;

    // Observe at the falling edge; the index recorded is the next rising edge.
    always @(negedge clk) begin
        if (bus.data_valid === 1'b1) begin
            dv_cyc.push_back(cyc + 1);
            dv_dat.push_back(int'(bus.data_out));
        end
        if (bus.code_err === 1'b1) ce_cyc.push_back(cyc + 1);
        if (bus.busy === 1'b1) busy_hi_cnt <= busy_hi_cnt + 1;
        if (bus.busy === 1'b1 && !busy_prev) rise_q.push_back(cyc + 1);
        if (bus.busy !== 1'b1 && busy_prev) fall_q.push_back(cyc + 1);
        if (bus.data_valid === 1'b1 && dv_prev) dv_wide <= dv_wide + 1;
        if (bus.code_err === 1'b1 && ce_prev) ce_wide <= ce_wide + 1;
        if (bus.data_valid === 1'b1 && bus.code_err === 1'b1) both_cnt <= both_cnt + 1;
        busy_prev <= (bus.busy === 1'b1);
        dv_prev   <= (bus.data_valid === 1'b1);
        ce_prev   <= (bus.code_err === 1'b1);
    end

    int b_dv, b_ce, b_rise, b_fall, b_hi;

    function automatic int qat(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input int n);
        bus.rto_in = v;
        repeat (n) tick();
    endtask

    task automatic snap();
        b_dv   = dv_cyc.size();
        b_ce   = ce_cyc.size();
        b_rise = rise_q.size();
        b_fall = fall_q.size();
        b_hi   = busy_hi_cnt;
    endtask

    // bad_bit: that bit's second half is forced low, then the frame is abandoned.
    // cut_bit: only the first quarter of that bit is sent, then the frame is abandoned.
    task automatic send_frame(input logic [7:0] d, input int bad_bit, input int cut_bit,
                              output int e0);
        e0 = cyc + 1;
        drive(1'b0, OVS / 2);
        drive(1'b1, OVS / 2);
        for (int k = 0; k < DATA_W; k++) begin
            if (k == cut_bit) begin
                drive(d[k], OVS / 4);
                return;
            end
            if (k == bad_bit) begin
                drive(d[k], OVS / 2);
                drive(1'b0, OVS / 2);
                bus.rto_in = 1'b1;
                return;
            end
            if (d[k]) begin
                drive(1'b1, OVS);
            end else begin
                drive(1'b0, OVS / 2);
                drive(1'b1, OVS / 2);
            end
        end
        drive(1'b1, OVS);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, observed=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int e0;
        int e0b;

        // Reset held with the line low, released with the line idle.
        rst        = 1'b1;
        bus.rto_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("reset_outs", 32'({bus.data_out, bus.data_valid, bus.code_err, bus.busy}), 32'd0);
        end
        rst        = 1'b0;
        bus.rto_in = 1'b1;
        snap();
        drive(1'b1, 50);
        check("idle_busy_cycles", busy_hi_cnt - b_hi, 0);
        check("idle_dv_count", dv_cyc.size() - b_dv, 0);
        check("idle_outs", 32'({bus.data_out, bus.data_valid, bus.code_err, bus.busy}), 32'd0);

        // Single clean frame 0xA5.
        snap();
        send_frame(8'hA5, -1, -1, e0);
        drive(1'b1, 20);
        check("a5_dv_count", dv_cyc.size() - b_dv, 1);
        check("a5_dv_cycle", qat(dv_cyc, b_dv), e0 + 151);
        check("a5_dv_data", qat(dv_dat, b_dv), 32'hA5);
        check("a5_ce_count", ce_cyc.size() - b_ce, 0);
        check("a5_busy_rise", qat(rise_q, b_rise), e0 + 3);
        check("a5_busy_fall", qat(fall_q, b_fall), e0 + 152);
        check("a5_data_hold", bus.data_out, 32'hA5);

        // Back-to-back 0x00 then 0xFF, second start right after the first stop.
        snap();
        send_frame(8'h00, -1, -1, e0);
        send_frame(8'hFF, -1, -1, e0b);
        drive(1'b1, 20);
        check("b2b_dv_count", dv_cyc.size() - b_dv, 2);
        check("b2b_first_data", qat(dv_dat, b_dv), 32'h00);
        check("b2b_first_cycle", qat(dv_cyc, b_dv), e0 + 151);
        check("b2b_second_data", qat(dv_dat, b_dv + 1), 32'hFF);
        check("b2b_second_cycle", qat(dv_cyc, b_dv + 1), e0b + 151);
        check("b2b_ce_count", ce_cyc.size() - b_ce, 0);

        // Three-cycle glitch: false start, no flags.
        snap();
        e0 = cyc + 1;
        drive(1'b0, 3);
        drive(1'b1, 30);
        check("glitch_busy_rise", qat(rise_q, b_rise), e0 + 3);
        check("glitch_busy_fall", qat(fall_q, b_fall), e0 + 2 + OVS / 4 + 1);
        check("glitch_dv_count", dv_cyc.size() - b_dv, 0);
        check("glitch_ce_count", ce_cyc.size() - b_ce, 0);

        // 0x3C with bit 3 failing to return high.
        snap();
        send_frame(8'h3C, 3, -1, e0);
        drive(1'b1, 40);
        check("viol_ce_count", ce_cyc.size() - b_ce, 1);
        check("viol_ce_cycle", qat(ce_cyc, b_ce), e0 + 2 + 77);
        check("viol_dv_count", dv_cyc.size() - b_dv, 0);
        check("viol_data_hold", bus.data_out, 32'hFF);
        check("viol_busy", bus.busy, 1'b0);

        snap();
        send_frame(8'h5A, -1, -1, e0);
        drive(1'b1, 20);
        check("after_viol_dv_count", dv_cyc.size() - b_dv, 1);
        check("after_viol_data", qat(dv_dat, b_dv), 32'h5A);
        check("after_viol_cycle", qat(dv_cyc, b_dv), e0 + 151);
        check("after_viol_ce_count", ce_cyc.size() - b_ce, 0);

        // One-cycle reset during data bit 5 of a frame.
        snap();
        send_frame(8'h6D, -1, 5, e0);
        check("pre_rst_busy", bus.busy, 1'b1);
        rst        = 1'b1;
        bus.rto_in = 1'b1;
        tick();
        check("mid_rst_outs", 32'({bus.data_out, bus.data_valid, bus.code_err, bus.busy}), 32'd0);
        rst = 1'b0;
        drive(1'b1, 40);
        check("mid_rst_dv_count", dv_cyc.size() - b_dv, 0);
        check("mid_rst_ce_count", ce_cyc.size() - b_ce, 0);
        check("mid_rst_busy_cycles_after", bus.busy, 1'b0);

        snap();
        send_frame(8'hC3, -1, -1, e0);
        drive(1'b1, 20);
        check("post_rst_dv_count", dv_cyc.size() - b_dv, 1);
        check("post_rst_cycle", qat(dv_cyc, b_dv), e0 + 151);
        check("post_rst_data", qat(dv_dat, b_dv), 32'hC3);
        check("post_rst_data_hold", bus.data_out, 32'hC3);

        check("dv_pulse_width", dv_wide, 0);
        check("ce_pulse_width", ce_wide, 0);
        check("dv_ce_overlap", both_cnt, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/rto_frame_decoder.md
Name: rto_frame_decoder

Overview:
- Receiver for the return-to-one (RTO) serial line code generated by the design's RTO transmitter top.
- Oversamples the incoming line on the system clock, detects frame start and recovers DATA_W data bits, LSB first.
- Flags code violations and hands each completed word to downstream DSP logic with a one-cycle valid strobe.

Parameters:
OVS, 16, system clocks per RTO bit period; must be a multiple of 4 and at least 8
DATA_W, 8, data bits per frame

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  reset, synchronous, active-high
rto_in  input  1  RTO serial line, asynchronous to clk; idle level 1
data_out  output  DATA_W  last correctly received word
data_valid  output  1  one-cycle pulse: data_out updated this cycle
code_err  output  1  one-cycle pulse: frame aborted on code/framing violation
busy  output  1  high while state is not IDLE

Behaviour:
- Line coding, per bit period:
  - 0 bit: first half low, second half high.
  - 1 bit: high for the whole period.
- Frame format: start bit (0), DATA_W data bits LSB first, stop bit (1).
- Every bit period, including start, must return high in its second half.
- Input synchroniser: 2 flops plus a registered previous value for edge detection. All three reset to 1, so releasing reset can never produce a false edge.
- Timing reference: let E0 be the first clk edge that samples rto_in=0. The falling edge is detected in IDLE at T = E0+2.
- Bit-phase counter cnt (0..OVS-1):
  - Loaded with 1 at T+1, increments every cycle, wraps at OVS-1.
  - Each wrap advances the bit index.
  - Sample point: cnt==OVS/4. Return check: cnt==3*OVS/4.
- States:
  - IDLE: waits for a synchronised falling edge, then goes to START. A line held low does not retrigger; a new 1->0 transition is required.
  - START:
    - If the line is 1 at the sample point (T+OVS/4): false start; return to IDLE with no flags.
    - If the line is 0 at the return check: code_err, go to IDLE.
    - On wrap: go to DATA with bit index 0.
  - DATA:
    - Data bit k is sampled at T+(k+1)*OVS+OVS/4 into a shift register, LSB first.
    - Line 0 at the return check: code_err, go to IDLE.
    - After bit DATA_W-1 wraps: go to STOP.
  - STOP:
    - Sample at T+(DATA_W+1)*OVS+OVS/4.
    - If 1: on the next cycle, load data_out from the shift register, pulse data_valid, and go to IDLE.
    - If 0: code_err and go to IDLE.
- Latency at OVS=16, DATA_W=8: data_valid at T+149 = E0+151.
- Re-arm: IDLE is re-entered before the end of the stop period, so a start bit arriving immediately after the stop bit is captured.
- code_err is registered: it is high in the cycle after the failing check.
- On error, data_out is not modified and data_valid is not asserted for that frame.
- data_valid and code_err are never high together. Each is high for exactly one cycle per event.
- data_out holds its value between frames.
- Reset values: data_out=0, data_valid=0, code_err=0, busy=0. State is IDLE, cnt=0, shift register=0.
- Reset mid-frame: on the cycle after rst is sampled high, all of the reset values above apply and the partial frame is discarded. Reset overrides every other event in the same cycle.

Test Plan:
1. Hold rst=1 for 3 cycles with rto_in=0, release with rto_in=1 -> all outputs 0 during and after reset; busy stays 0 for 50 cycles.
2. OVS=16, send 0xA5 -> data_out=0xA5 and data_valid high for exactly one cycle at E0+151; code_err stays 0; busy falls the cycle after data_valid.
3. Send 0x00 then 0xFF back-to-back, with the second start bit immediately after the first stop bit -> two data_valid pulses with 0x00 then 0xFF; no code_err.
4. Drive rto_in low for 3 cycles, then high -> no data_valid and no code_err; busy high from T+1 and low again from T+OVS/4+1.
5. Send 0x3C with bit 3's second half held low -> code_err pulse at T+4*OVS+3*OVS/4+1 = T+77; no data_valid; data_out keeps its previous value; the next clean frame 0x5A is received correctly.
6. Assert rst for 1 cycle during data bit 5 -> outputs return to reset values the next cycle; a following frame 0xC3 is received with data_valid at E0+151 of that frame.
